regfile_wr_arb: RTL
===================

# regfile_wr_arb

Round-robin write arbiter that sits directly upstream of the multi-port register file. It collects register-write requests from N_REQ producers (execution units, load return, CSR path) over valid/ready handshakes. Each cycle it grants up to N_WPORTS of them, never two to the same register address. Granted writes are driven through registered outputs onto the register file's write-port bus (waddr/wen/wdata), one cycle after acceptance.

## Interface
- WIDTH, 32, data width of each register
- N_REG, 32, number of registers; address width AW = $clog2(N_REG)
- N_REQ, 4, number of requesting producers (≥1)
- N_WPORTS, 2, number of register-file write ports (1 ≤ N_WPORTS ≤ N_REQ)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  [N_REQ]  producer i has a write pending
- req_addr  in  [N_REQ][AW]  target register of request i
- req_data  in  [N_REQ][WIDTH]  write data of request i
- req_ready  out  [N_REQ]  request i accepted this cycle (combinational)
- stall  in  1  register file cannot take writes; no grants this cycle
- waddr  out  [N_WPORTS][AW]  registered write address per port
- wen  out  [N_WPORTS]  registered write enable per port
- wdata  out  [N_WPORTS][WIDTH]  registered write data per port

## Operation
- Grant scan visits requesters in order rr_ptr, rr_ptr+1, … mod N_REQ.
- Requester i is granted if all of the following hold:
  - req_valid[i]=1 and stall=0;
  - fewer than N_WPORTS grants have been made so far this cycle;
  - req_addr[i] differs from every address already granted this cycle.
- A skipped requester stays pending; no data is dropped.
- req_ready[i] = grant[i]. A transfer is valid&ready. Producers hold valid/addr/data stable until ready; the block does not buffer.
- The k-th grant in scan order is assigned to write port k. Ports beyond the grant count get wen=0.
- rr_ptr state, AW_REQ = $clog2(N_REQ) bits (1 bit when N_REQ=1):
  - if ≥1 grant: rr_ptr ← (index of last granted requester + 1) mod N_REQ;
  - if 0 grants (including stall): rr_ptr unchanged.
- Output register load:
  - wen[k] ← grant-present for port k, every cycle.
  - waddr/wdata[k] load only when port k is granted, otherwise they hold.
- Fairness bound: a continuously valid requester is granted within N_REQ cycles, unless stall is held or its address collides.

## Timing
- Reset (rst_n=0, asynchronous): wen=0, waddr=0, wdata=0, rr_ptr=0. req_ready=0 while rst_n=0.
- Latency: request accepted in cycle t → wen[k]=1 with that addr/data in cycle t+1, for exactly one cycle.
- stall=1 in cycle t: req_ready all 0 in t, wen all 0 in t+1. stall is combinational to req_ready only.
- Reset asserted mid-operation: any write registered but not yet presented is discarded (wen forced 0). Producers must re-present.
- Same-address collision: only the first requester in scan order is granted. The second is granted no earlier than the next cycle.
- rr_ptr wrap: last grant at index N_REQ-1 → rr_ptr=0.
- No combinational path from inputs to waddr/wen/wdata.

## Structure
- Shared package regfile_pkg: round-robin rotate/index helper function and the rr pointer width computation, so the read-side and scoreboard blocks reuse them.
- One natural sub-module: regfile_wr_pick, combinational scan. Inputs: valid, addr, rr_ptr, stall. Outputs: grant vector, per-port requester index, per-port valid, last-granted index.
- Top level holds rr_ptr and the output registers.

## Test plan
- Reset: rst_n=0 with all req_valid=1 → req_ready=0, wen=0, waddr=0, wdata=0. Release rst_n → first grants go to req 0 and req 1 (N_WPORTS=2).
- Round-robin: all 4 valid, distinct addrs 1,2,3,4, held 4 cycles.
  - Grants alternate {0,1},{2,3},{0,1},{2,3}.
  - wen=2'b11 each cycle from t+1; port0 sees addr 1,3,1,3.
- Collision: req0 and req1 both addr 5, data 0xA/0xB, rr_ptr=0.
  - Cycle t: only req0 granted. Cycle t+1: waddr[0]=5, wdata[0]=0xA, wen=2'b01.
  - req1 granted in cycle t+1; its write appears in t+2.
- Stall: all valid, stall=1 for 3 cycles → req_ready=0 and wen=0 throughout, rr_ptr unchanged. After release, grants resume at the same rr_ptr.
- Sparse/wrap: only req3 valid, addr 7, data 0x55 → granted to port 0. Next cycle wen=2'b01, waddr[0]=7; rr_ptr=0.
- Reset mid-flight: rst_n low in the cycle after a grant → wen=0 immediately, and no stale write after rst_n rises.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared round-robin helpers for the register-file write/read arbitration blocks
package regfile_pkg;

    function automatic int rr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int rr_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/regfile_wr_pick.sv
// regfile_wr_pick: round-robin scan choosing up to N_WPORTS requesters with distinct addresses
module regfile_wr_pick
    import regfile_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int N_WPORTS = 2,
    parameter int AW       = 5,
    localparam int PW      = rr_width(N_REQ)
) (
    input  logic [N_REQ-1:0]            valid,
    input  logic [N_REQ-1:0][AW-1:0]    addr,
    input  logic [PW-1:0]               rr_ptr,
    input  logic                        stall,
    output logic [N_REQ-1:0]            grant,
    output logic [N_WPORTS-1:0][PW-1:0] port_idx,
    output logic [N_WPORTS-1:0]         port_vld,
    output logic [PW-1:0]               last_idx
);
    localparam int CW = $clog2(N_WPORTS + 1);

    logic [CW-1:0] cnt;
    logic [PW-1:0] idx;
    logic          hit;

    // walk requesters from rr_ptr, handing each eligible one the next free port
    always_comb begin
        grant    = '0;
        port_idx = '0;
        port_vld = '0;
        last_idx = rr_ptr;
        cnt      = '0;
        idx      = '0;
        hit      = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            idx = PW'(rr_idx(int'(rr_ptr), j, N_REQ));
            hit = 1'b0;
            for (int k = 0; k < N_WPORTS; k++)
                hit = hit | (port_vld[k] && addr[port_idx[k]] == addr[idx]);
            if (valid[idx] && !stall && !hit && int'(cnt) < N_WPORTS) begin
                for (int k = 0; k < N_WPORTS; k++)
                    if (k == int'(cnt)) begin
                        port_idx[k] = idx;
                        port_vld[k] = 1'b1;
                    end
                grant[idx] = 1'b1;
                last_idx   = idx;
                cnt        = cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: round-robin register-file write arbiter with registered write-port outputs
module regfile_wr_arb
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int N_REG    = 32,
    parameter int N_REQ    = 4,
    parameter int N_WPORTS = 2,
    localparam int AW      = $clog2(N_REG)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ-1:0][AW-1:0]      req_addr,
    input  logic [N_REQ-1:0][WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]              req_ready,
    input  logic                          stall,
    output logic [N_WPORTS-1:0][AW-1:0]   waddr,
    output logic [N_WPORTS-1:0]           wen,
    output logic [N_WPORTS-1:0][WIDTH-1:0] wdata
);
    localparam int PW = rr_width(N_REQ);

    logic [PW-1:0]               rr_ptr;
    logic [N_REQ-1:0]            grant;
    logic [N_WPORTS-1:0][PW-1:0] port_idx;
    logic [N_WPORTS-1:0]         port_vld;
    logic [PW-1:0]               last_idx;

    regfile_wr_pick #(
        .N_REQ   (N_REQ),
        .N_WPORTS(N_WPORTS),
        .AW      (AW)
    ) u_pick (
        .valid   (req_valid),
        .addr    (req_addr),
        .rr_ptr  (rr_ptr),
        .stall   (stall),
        .grant   (grant),
        .port_idx(port_idx),
        .port_vld(port_vld),
        .last_idx(last_idx)
    );

    assign req_ready = grant & {N_REQ{rst_n}};

    // advance the pointer past the last grant and register granted writes onto their ports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            wen    <= '0;
            waddr  <= '0;
            wdata  <= '0;
        end else begin
            if (port_vld[0])
                rr_ptr <= PW'(rr_idx(int'(last_idx), 1, N_REQ));
            wen <= port_vld;
            for (int k = 0; k < N_WPORTS; k++)
                if (port_vld[k]) begin
                    waddr[k] <= req_addr[port_idx[k]];
                    wdata[k] <= req_data[port_idx[k]];
                end
        end
    end

endmodule
